// File: rtl/frame_sync_pkg.sv
// frame_sync shared types and constants.
// Symbol codes, FSM states and the CRC polynomial used by the receive chain.
package frame_sync_pkg;

  typedef enum logic [2:0] {
    HUNT,
    SFD_HI,
    PHR_LO,
    PHR_HI,
    PAYLOAD
  } state_t;

  localparam logic [3:0] SYM_PREAMBLE = 4'h0;
  localparam logic [3:0] SYM_SFD_LO   = 4'h7;
  localparam logic [3:0] SYM_SFD_HI   = 4'hA;
  localparam logic [15:0] CRC_POLY    = 16'h1021;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/frame_sync_if.sv
// frame_sync symbol/FIFO bundle.
// outCrcOk exists only when FRAME_SYNC_CRC_EN is defined.
interface frame_sync_if;
  logic [3:0] inSymbol;
  logic       inSymbolValid;
  logic       inFull;
  logic [3:0] outSymbol;
  logic       outWriteEnable;
  logic       outFrameActive;
  logic [6:0] outLength;
  logic       outFrameDone;
  logic       outFrameError;
`ifdef FRAME_SYNC_CRC_EN
  logic       outCrcOk;
`endif

  modport master (
    output inSymbol, inSymbolValid, inFull,
`ifdef FRAME_SYNC_CRC_EN
    input  outCrcOk,
`endif
    input  outSymbol, outWriteEnable, outFrameActive,
    input  outLength, outFrameDone, outFrameError
  );

  modport slave (
    input  inSymbol, inSymbolValid, inFull,
`ifdef FRAME_SYNC_CRC_EN
    output outCrcOk,
`endif
    output outSymbol, outWriteEnable, outFrameActive,
    output outLength, outFrameDone, outFrameError
  );
endinterface

// File: rtl/frame_sync_crc16.sv
// Nibble-wide CRC-16 (0x1021, LSB-first) next-state logic plus register.
// Used by frame_sync only when FRAME_SYNC_CRC_EN is defined.
module crc16_nibble
  import frame_sync_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [3:0]  nibble,
  output logic [15:0] crcNext
);
  localparam logic [15:0] PolyRef = reflect16(CRC_POLY);

  logic [15:0] crc;

  always_comb begin
    crcNext = crc;
    for (int b = 0; b < 4; b++) begin
      crcNext = (crcNext >> 1) ^
        ((crcNext[0] ^ nibble[b]) ? PolyRef : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) crc <= 16'h0000;
    else if (enable)  crc <= crcNext;
  end
endmodule

// File: rtl/frame_sync.sv
// 802.15.4 preamble/SFD hunter, PHR length extractor, payload forwarder.
// Define FRAME_SYNC_CRC_EN to add the outCrcOk payload CRC check.
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int PREAMBLE_MIN = 4,
  parameter int TIMEOUT      = 1023,
  parameter int MIN_LEN      = 1
) (
  input logic         inClock,
  input logic         inReset,
  frame_sync_if.slave bus
);
  localparam logic [3:0]  PreMin = 4'(PREAMBLE_MIN);
  localparam logic [16:0] GapMax = 17'(TIMEOUT);
  localparam logic [6:0]  MinLen = 7'(MIN_LEN);

  state_t      state, stateNext;
  logic [3:0]  preCount, preCountNext;
  logic [15:0] gap, gapNext;
  logic [16:0] gapInc;
  logic [7:0]  remain, remainNext;
  logic [3:0]  lenLo, lenLoNext;
  logic [6:0]  phrLen;
  logic [3:0]  symReg, symNext;
  logic [6:0]  lenReg, lenNext;
  logic        weReg, weNext;
  logic        actReg, actNext;
  logic        doneReg, doneNext;
  logic        errReg, errNext;

  assign gapInc = {1'b0, gap} + 17'd1;
  assign phrLen = {bus.inSymbol[2:0], lenLo};

  always_comb begin
    stateNext    = state;
    preCountNext = preCount;
    gapNext      = gap;
    remainNext   = remain;
    lenLoNext    = lenLo;
    symNext      = symReg;
    lenNext      = lenReg;
    weNext       = 1'b0;
    actNext      = actReg;
    doneNext     = 1'b0;
    errNext      = 1'b0;

    if (!bus.inSymbolValid) begin
      if (state != HUNT) begin
        gapNext = gapInc[15:0];
        // SFD_HI has no frame open yet, so its timeout is silent
        if (gapInc == GapMax) begin
          stateNext    = HUNT;
          preCountNext = 4'd0;
          gapNext      = 16'd0;
          actNext      = 1'b0;
          errNext      = (state != SFD_HI);
        end
      end
    end else begin
      gapNext = 16'd0;
      unique case (state)
        HUNT: begin
          if (bus.inSymbol == SYM_PREAMBLE) begin
            if (preCount != 4'hF) preCountNext = preCount + 4'd1;
          end else if (bus.inSymbol == SYM_SFD_LO &&
                       preCount >= PreMin) begin
            stateNext    = SFD_HI;
            preCountNext = 4'd0;
          end else begin
            preCountNext = 4'd0;
          end
        end
        SFD_HI: begin
          if (bus.inSymbol == SYM_SFD_HI) begin
            stateNext = PHR_LO;
            actNext   = 1'b1;
          end else begin
            stateNext    = HUNT;
            preCountNext = (bus.inSymbol == SYM_PREAMBLE) ? 4'd1 : 4'd0;
          end
        end
        PHR_LO: begin
          lenLoNext = bus.inSymbol;
          stateNext = PHR_HI;
        end
        PHR_HI: begin
          if (phrLen < MinLen) begin
            errNext      = 1'b1;
            actNext      = 1'b0;
            stateNext    = HUNT;
            preCountNext = 4'd0;
          end else begin
            remainNext = {phrLen, 1'b0};
            lenNext    = phrLen;
            stateNext  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (bus.inFull) begin
            errNext      = 1'b1;
            actNext      = 1'b0;
            stateNext    = HUNT;
            preCountNext = 4'd0;
          end else begin
            weNext     = 1'b1;
            symNext    = bus.inSymbol;
            remainNext = remain - 8'd1;
            if (remain == 8'd1) begin
              doneNext     = 1'b1;
              actNext      = 1'b0;
              stateNext    = HUNT;
              preCountNext = 4'd0;
            end
          end
        end
        default: stateNext = HUNT;
      endcase
    end
  end

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state    <= HUNT;
      preCount <= 4'd0;
      gap      <= 16'd0;
      remain   <= 8'd0;
      lenLo    <= 4'd0;
      symReg   <= 4'd0;
      lenReg   <= 7'd0;
      weReg    <= 1'b0;
      actReg   <= 1'b0;
      doneReg  <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      state    <= stateNext;
      preCount <= preCountNext;
      gap      <= gapNext;
      remain   <= remainNext;
      lenLo    <= lenLoNext;
      symReg   <= symNext;
      lenReg   <= lenNext;
      weReg    <= weNext;
      actReg   <= actNext;
      doneReg  <= doneNext;
      errReg   <= errNext;
    end
  end

  assign bus.outSymbol      = symReg;
  assign bus.outWriteEnable = weReg;
  assign bus.outFrameActive = actReg;
  assign bus.outLength      = lenReg;
  assign bus.outFrameDone   = doneReg;
  assign bus.outFrameError  = errReg;

`ifdef FRAME_SYNC_CRC_EN
  logic        sfdAccept;
  logic [15:0] crcNext;
  logic        crcOk;

  assign sfdAccept = (state == SFD_HI) && (stateNext == PHR_LO);

  crc16_nibble uCrc (
    .clk    (inClock),
    .rst    (inReset),
    .clear  (sfdAccept),
    .enable (weNext),
    .nibble (bus.inSymbol),
    .crcNext(crcNext)
  );

  always_ff @(posedge inClock) begin
    if (inReset || sfdAccept) crcOk <= 1'b0;
    else if (doneNext)        crcOk <= (crcNext == 16'h0000);
  end

  assign bus.outCrcOk = crcOk;
`endif
endmodule
